// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Debug-UART receive front end. Synchronises the asynchronous rxd
//             pin, recovers 8N1 frames using 16x oversampling with a 3-sample
//             majority vote, and buffers bytes in a small FIFO that a
//             valid/ready consumer drains.
//  Ports    : clk        system clock, posedge
//             rst        synchronous active-high reset
//             rxd        serial input, idle high
//             out_data   byte at FIFO head (0 when empty)
//             out_valid  FIFO non-empty
//             out_ready  consumer pops when out_valid && out_ready
//             count      FIFO occupancy, 0..DEPTH
//             frame_err  1-cycle pulse, stop bit sampled low
//             overrun    1-cycle pulse, byte dropped because FIFO full
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DIV   = 109,  // clk cycles per oversample tick, >= 2
  parameter int DEPTH = 8     // FIFO entries, power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxd,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t         state_q;
  logic           rx_meta_q;
  logic           rx_s_q;
  logic [DW-1:0]  div_q;
  logic [3:0]     s_q;
  logic [1:0]     smp_q;
  logic [2:0]     bit_q;
  logic [7:0]     shreg_q;
  logic           frame_err_q;
  logic           overrun_q;

  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;

  logic           w_tick;
  logic           w_mid;
  logic           w_maj;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_wr;

  // The divider only runs while a frame is being timed.
  assign w_tick = (state_q == S_START || state_q == S_DATA || state_q == S_STOP) &&
                  (div_q == DW'(DIV - 1));
  // Third vote comes straight from rx_s on the s=9 tick itself.
  assign w_maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign w_mid  = w_tick && (s_q == 4'd9);
  assign w_push = (state_q == S_STOP) && w_mid && w_maj;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      s_q         <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;

      if (state_q == S_IDLE || state_q == S_BREAK) begin
        div_q <= '0;
      end else if (w_tick) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end

      if (w_tick) begin
        s_q <= s_q + 4'd1;
        if (s_q == 4'd7) smp_q[0] <= rx_s_q;
        if (s_q == 4'd8) smp_q[1] <= rx_s_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            s_q     <= '0;
          end
        end
        S_START: begin
          if (w_mid && w_maj) begin
            state_q <= S_IDLE;          // glitch, not a real start bit
          end else if (w_tick && s_q == 4'd15) begin
            state_q <= S_DATA;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (w_mid) shreg_q <= {w_maj, shreg_q[7:1]};
          if (w_tick && s_q == 4'd15) begin
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          if (w_mid) begin
            if (w_maj) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_BREAK;
              frame_err_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_pop  = out_valid && out_ready;
  assign w_full = (count_q == CW'(DEPTH));
  // A full FIFO still accepts the byte when a pop frees a slot that cycle.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_comb begin
    count_d = count_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (w_wr)  wr_q <= wr_q + AW'(1);
      if (w_pop) rd_q <= rd_q + AW'(1);
      count_q   <= count_d;
      overrun_q <= w_push && w_full && !w_pop;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : 8'h00;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo (DIV=4, DEPTH=8, 64 clk
//             per bit). Expected bytes are queued as frames are sent and
//             compared whenever the consumer pops a byte.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DIV     = 4;
  localparam int DEPTH   = 8;
  localparam int BIT_CLK = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pop_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] sb_q[$];

  uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sb_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
        else                  check("pop_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic expect_byte);
    if (expect_byte) sb_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int o0;
    rst       = 1'b1;
    rxd       = 1'b1;
    out_ready = 1'b0;
    idle(3);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_data",  {24'd0, out_data}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Single byte with immediate consumer.
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(4);
    check("b55_pops",  pop_cnt - p0, 32'd1);
    check("b55_count", {28'd0, count}, 32'd0);

    // Short low glitch must be rejected.
    p0 = pop_cnt;
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(700);
    check("glitch_pops",  pop_cnt - p0, 32'd0);
    check("glitch_ferr",  ferr_cnt, 32'd0);
    check("glitch_count", {28'd0, count}, 32'd0);

    // Framing error, line held in break, then recovery.
    send_frame(8'hA3, 1'b0, 1'b0);
    idle(100);
    check("ferr_cnt",   ferr_cnt, 32'd1);
    check("ferr_count", {28'd0, count}, 32'd0);
    rxd = 1'b1;
    idle(BIT_CLK);
    p0 = pop_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    check("b3c_pops", pop_cnt - p0, 32'd1);
    check("ferr_once", ferr_cnt, 32'd1);

    // Overrun: nine bytes into an eight-entry FIFO with no consumer.
    out_ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i < 9; i++) send_frame(i[7:0], 1'b1, i < 8);
    idle(10);
    check("ovr_count", {28'd0, count}, 32'd8);
    check("ovr_pulses", ovr_cnt - o0, 32'd1);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_head",  {24'd0, out_data}, 32'd0);
    out_ready = 1'b1;
    idle(20);
    out_ready = 1'b0;
    check("ovr_drained", {28'd0, count}, 32'd0);
    check("ovr_sb_empty", sb_q.size(), 32'd0);

    // Full FIFO with a pop on exactly the push cycle of the ninth byte.
    o0 = ovr_cnt;
    for (int i = 0; i < 8; i++) send_frame(i[7:0], 1'b1, 1'b1);
    check("full_count", {28'd0, count}, 32'd8);
    fork
      send_frame(8'h08, 1'b1, 1'b1);
      begin
        // Push lands on the 619th posedge after the start bit is driven.
        repeat (618) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
      end
    join
    idle(4);
    check("sim_count", {28'd0, count}, 32'd8);
    check("sim_no_ovr", ovr_cnt - o0, 32'd0);
    check("sim_head", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    idle(20);
    out_ready = 1'b0;
    check("sim_drained", {28'd0, count}, 32'd0);
    check("sim_sb_empty", sb_q.size(), 32'd0);

    // Reset in the middle of a frame with two bytes queued.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(4);
    check("pre_rst_count", {28'd0, count}, 32'd2);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rxd = 1'b1;
    idle(20);
    rst = 1'b1;
    sb_q.delete();
    idle(1);
    rst = 1'b0;
    idle(2);
    check("post_rst_count", {28'd0, count}, 32'd0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    idle(700);
    check("post_rst_idle", {28'd0, count}, 32'd0);
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(4);
    check("b7e_pops", pop_cnt - p0, 32'd1);
    check("final_sb_empty", sb_q.size(), 32'd0);
    check("final_ferr", ferr_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
